// File: rtl/reset_seq_gen.sv
// Reset release sequencer: holds every domain reset low, then releases domains in index order, one per ack.
// Outputs are registered (test_mode bypass is combinational); a missing ack times out so the sequence never stalls.
module reset_seq_gen #(
  parameter int NUM_DOM     = 4,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 10,
  parameter int STRETCH     = 16,
  parameter int GAP         = 8,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               inreset_,
  input  logic               test_mode,
  input  logic               direct_reset_,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] rst_ack,
  output logic [NUM_DOM-1:0] outreset_,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_timeout,
  output logic [IDX_W-1:0]   timeout_dom
);

  typedef enum logic [2:0] {
    S_ASSERT,
    S_RELEASE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] C_STRETCH_M1 = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] C_GAP_M1     = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] C_TO_M1      = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(NUM_DOM - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_DOM-1:0] r_ack_s1;
  logic [NUM_DOM-1:0] r_ack_s2;
  logic [NUM_DOM-1:0] r_outreset;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout;
  logic [IDX_W-1:0]   r_timeout_dom;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_ack;
  logic               w_last;

  // Saturating count: a wrapped counter could re-trigger a stretch or gap expiry.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_idx_nxt = r_idx + IDX_W'(1);
  assign w_ack     = r_ack_s2[r_idx];
  assign w_last    = (r_idx == C_LAST_IDX);

  // The cnt is cleared on the edge that releases a domain, so it counts cycles since release.
  always_ff @(posedge clk or negedge inreset_) begin
    if (!inreset_) begin
      r_state       <= S_ASSERT;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_ack_s1      <= '0;
      r_ack_s2      <= '0;
      r_outreset    <= '0;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_timeout_dom <= '0;
    end else begin
      r_ack_s1  <= rst_ack;
      r_ack_s2  <= r_ack_s1;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_ASSERT: begin
          if (r_cnt >= C_STRETCH_M1) begin
            r_outreset[r_idx] <= 1'b1;
            r_cnt             <= '0;
            r_state           <= S_RELEASE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RELEASE: begin
          r_cnt   <= w_cnt_inc;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (w_ack || (r_cnt >= C_TO_M1)) begin
            if (!w_ack) begin
              r_timeout     <= 1'b1;
              r_timeout_dom <= r_idx;
            end
            r_cnt <= '0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_GAP: begin
          if (r_cnt >= C_GAP_M1) begin
            r_idx                 <= w_idx_nxt;
            r_outreset[w_idx_nxt] <= 1'b1;
            r_cnt                 <= '0;
            r_state               <= S_RELEASE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (sw_rst_req) begin
            r_outreset    <= '0;
            r_busy        <= 1'b1;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_timeout_dom <= '0;
            r_state       <= S_ASSERT;
          end
        end
        default: begin
          r_outreset <= '0;
          r_busy     <= 1'b1;
          r_cnt      <= '0;
          r_idx      <= '0;
          r_state    <= S_ASSERT;
        end
      endcase
    end
  end

  assign outreset_   = test_mode ? {NUM_DOM{direct_reset_}} : r_outreset;
  assign seq_busy    = r_busy;
  assign seq_done    = r_done;
  assign seq_timeout = r_timeout;
  assign timeout_dom = r_timeout_dom;

endmodule
